// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - shared widths, bundle layout and state encoding for the ID/EX buffer
package idex_pkg;

  localparam int IDEX_DATA_W = 32;
  localparam int IDEX_RA_W   = 5;
  localparam int IDEX_WB_W   = 2;
  localparam int IDEX_M_W    = 2;
  localparam int IDEX_EX_W   = 4;
  localparam int IDEX_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } slot_state_e;

  // Bundle layout, LSB first: rd, rt, rs, imm, rd2, rd1, ex, m, wb.
  typedef enum int {
    F_RD, F_RT, F_RS, F_IMM, F_RD2, F_RD1, F_EX, F_M, F_WB
  } field_e;

  function automatic int bundle_w(int wb_w, int m_w, int ex_w, int data_w, int ra_w);
    return wb_w + m_w + ex_w + 3 * data_w + 3 * ra_w;
  endfunction

  function automatic int field_off(field_e f, int data_w, int ra_w, int ex_w, int m_w);
    case (f)
      F_RD:    return 0;
      F_RT:    return ra_w;
      F_RS:    return 2 * ra_w;
      F_IMM:   return 3 * ra_w;
      F_RD2:   return 3 * ra_w + data_w;
      F_RD1:   return 3 * ra_w + 2 * data_w;
      F_EX:    return 3 * ra_w + 3 * data_w;
      F_M:     return 3 * ra_w + 3 * data_w + ex_w;
      default: return 3 * ra_w + 3 * data_w + ex_w + m_w;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_buf_pipe_slot.sv
// rtl/id_ex_stage_buf_pipe_slot.sv - bundle-wide register with load enable and async reset
module pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_buf.sv
// rtl/id_ex_stage_buf.sv - ID/EX pipeline boundary with valid/ready, flush, skid entry and stall counter
module id_ex_stage_buf
  import idex_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int RA_W   = IDEX_RA_W,
  parameter int WB_W   = IDEX_WB_W,
  parameter int M_W    = IDEX_M_W,
  parameter int EX_W   = IDEX_EX_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = IDEX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [M_W-1:0]    m_in,
  input  logic [EX_W-1:0]   ex_in,
  input  logic [DATA_W-1:0] rd1_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [RA_W-1:0]   rs_in,
  input  logic [RA_W-1:0]   rt_in,
  input  logic [RA_W-1:0]   rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [M_W-1:0]    m_out,
  output logic [EX_W-1:0]   ex_out,
  output logic [DATA_W-1:0] rd1_out,
  output logic [DATA_W-1:0] rd2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [RA_W-1:0]   rs_out,
  output logic [RA_W-1:0]   rt_out,
  output logic [RA_W-1:0]   rd_out,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW    = bundle_w(WB_W, M_W, EX_W, DATA_W, RA_W);
  localparam int O_RD  = field_off(F_RD,  DATA_W, RA_W, EX_W, M_W);
  localparam int O_RT  = field_off(F_RT,  DATA_W, RA_W, EX_W, M_W);
  localparam int O_RS  = field_off(F_RS,  DATA_W, RA_W, EX_W, M_W);
  localparam int O_IMM = field_off(F_IMM, DATA_W, RA_W, EX_W, M_W);
  localparam int O_RD2 = field_off(F_RD2, DATA_W, RA_W, EX_W, M_W);
  localparam int O_RD1 = field_off(F_RD1, DATA_W, RA_W, EX_W, M_W);
  localparam int O_EX  = field_off(F_EX,  DATA_W, RA_W, EX_W, M_W);
  localparam int O_M   = field_off(F_M,   DATA_W, RA_W, EX_W, M_W);
  localparam int O_WB  = field_off(F_WB,  DATA_W, RA_W, EX_W, M_W);

  slot_state_e   state, state_n;
  logic          accept, consume;
  logic          head_load, skid_load, head_from_skid;
  logic [BW-1:0] in_bundle, head_d, head_q, skid_q;

  always_comb begin
    in_bundle = '0;
    in_bundle[O_RD  +: RA_W]   = rd_in;
    in_bundle[O_RT  +: RA_W]   = rt_in;
    in_bundle[O_RS  +: RA_W]   = rs_in;
    in_bundle[O_IMM +: DATA_W] = imm_in;
    in_bundle[O_RD2 +: DATA_W] = rd2_in;
    in_bundle[O_RD1 +: DATA_W] = rd1_in;
    in_bundle[O_EX  +: EX_W]   = ex_in;
    in_bundle[O_M   +: M_W]    = m_in;
    in_bundle[O_WB  +: WB_W]   = wb_in;
  end

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_n        = state;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_n   = ST_HEAD;
          head_load = 1'b1;
        end
      end
      ST_HEAD: begin
        if (accept && consume) begin
          head_load = 1'b1;
        end else if (accept && SKID != 0) begin
          state_n   = ST_FULL;
          skid_load = 1'b1;
        end else if (consume) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          state_n        = ST_HEAD;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle accept.
    if (flush) begin
      state_n   = ST_EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state_n != ST_EMPTY);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= (state_n != ST_FULL);
        end
      end
      assign in_ready = in_ready_q;

      pipe_slot #(.W(BW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_bundle),
        .q    (skid_q)
      );
    end else begin : g_single
      // Holds in_ready low until the first edge after reset releases.
      logic armed;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          armed <= 1'b0;
        end else begin
          armed <= 1'b1;
        end
      end
      assign in_ready = armed & (~out_valid | out_ready);
      assign skid_q   = '0;
    end
  endgenerate

  assign head_d = head_from_skid ? skid_q : in_bundle;

  pipe_slot #(.W(BW)) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (head_load),
    .d    (head_d),
    .q    (head_q)
  );

  assign wb_out  = out_valid ? head_q[O_WB +: WB_W] : '0;
  assign m_out   = out_valid ? head_q[O_M  +: M_W]  : '0;
  assign ex_out  = out_valid ? head_q[O_EX +: EX_W] : '0;
  assign rd1_out = head_q[O_RD1 +: DATA_W];
  assign rd2_out = head_q[O_RD2 +: DATA_W];
  assign imm_out = head_q[O_IMM +: DATA_W];
  assign rs_out  = head_q[O_RS  +: RA_W];
  assign rt_out  = head_q[O_RT  +: RA_W];
  assign rd_out  = head_q[O_RD  +: RA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
